sc_fir_sequencer: RTL and testbench
===================================

Name: sc_fir_sequencer

Overview:
- Control and sample front-end for the 39-tap stochastic FIR accelerator (HWA_1 datapath, instantiated as the HWA).
- Maintains the 39-entry sample delay line that drives the HWA binary inputs.
- For each accepted sample, runs the HWA for one full 2^N-cycle stochastic window, driving start, sel_bits and the R_y random stream.
- Captures the accumulated count and presents it downstream through a valid/ready handshake.

Parameters:
- N, 12, stochastic resolution; sel_bits/R_y width N, sample/result width N+1.
- NTAPS, 39, delay-line depth; must match the HWA input count.
- LFSR_SEED, 12'hACE, non-zero R_y seed.
- RESEED_EACH_RUN, 1, 1 = reload LFSR_SEED in START each run (deterministic per-sample); 0 = free-running across runs.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_in  in  N+1  new filter input sample.
- sample_valid  in  1  sample_in is valid.
- sample_ready  out  1  block accepts a sample this cycle.
- clear  in  1  synchronous zeroing of the delay line, honoured only in IDLE.
- tap_out  out  NTAPS x (N+1)  delay-line contents to HWA in[]; tap_out[0] is the newest sample.
- hwa_start  out  1  to HWA start.
- hwa_sel_bits  out  N  to HWA sel_bits.
- hwa_r_y  out  N  to HWA R_y.
- hwa_out  in  N+1  HWA accumulator output.
- hwa_done  in  1  HWA done.
- result  out  N+1  captured count.
- result_valid  out  1  result is available.
- result_ready  in  1  downstream accepts the result.
- busy  out  1  state is not IDLE.
- seq_err  out  1  sticky: hwa_done inconsistent with hwa_sel_bits.

Behaviour:
- Reset (async, reset_n=0), all values held until release:
  - state=IDLE; all taps 0; hwa_start=0; hwa_sel_bits=all-ones; hwa_r_y=LFSR_SEED.
  - result=0; result_valid=0; seq_err=0.
  - Reset mid-run aborts the run; no result is produced.
- States:
  - IDLE: sample_ready=1; hwa_sel_bits held all-ones so the HWA output stays cleared.
    - On sample_valid: shift the delay line (tap[0]<=sample_in, tap[i]<=tap[i-1], tap[NTAPS-1] discarded); go to START.
    - clear without sample_valid: zero all taps.
    - clear with sample_valid: the sample wins and clear is ignored.
  - START (1 cycle): hwa_start=1, hwa_sel_bits=all-ones. If RESEED_EACH_RUN, load LFSR_SEED. Next cycle: RUN with sel=0.
  - RUN: hwa_start=0; sel increments by 1 each cycle from 0 to 2^N-1.
    - LFSR advances every RUN cycle: Fibonacci form, x^12+x^6+x^4+x+1, never reaches 0.
    - In the cycle sel==2^N-1: result<=hwa_out, which is the sum of the HWA contributions for sel 0..2^N-2 (4095 cycles). Then go to HOLD.
  - HOLD: result_valid=1; result and taps stable; sel stays all-ones.
    - On result_ready: result_valid<=0, go to IDLE.
- sample_ready=0 outside IDLE; samples are never dropped or reordered.
- Latency, sample accepted at cycle t:
  - START at t+1.
  - RUN at t+2 .. t+2+2^N-1.
  - result_valid at t+2^N+2.
  - Earliest next sample accept: one cycle after the result handshake.
- hwa_sel_bits is registered; hwa_r_y is the LFSR register, so there is no combinational path from inputs to the HWA.
- seq_err is set when hwa_done != (hwa_sel_bits==all-ones) in any START/RUN/HOLD cycle. Only reset clears it.
- result is not saturated; it is N+1 bits and the maximum count is 2^N-1.
- result_ready asserted while result_valid=0 has no effect.

Decomposition:
- sc_fir_pkg holds:
  - SC_N=12, SC_POW2N=4096, SC_NTAPS=39.
  - seq_state_t enum {IDLE, START, RUN, HOLD}.
  - LFSR tap mask constant 12'h829, taps 12/6/4/1.
- One sub-module, sc_lfsr: an N-bit maximal LFSR with load/seed and enable ports.

Test Plan:
- Use an HWA stub whose out counts +1 per non-start, non-done cycle. Send one sample 13'h0800 at t=10 -> tap_out[0]=13'h0800, hwa_start high exactly at t=11, result=13'h0FFF, result_valid rising at t=4108.
- Push 40 samples 1..40 with result_ready tied 1 -> final tap_out[0]=40, tap_out[38]=2. Exactly 40 results; sample_ready low for the whole of each run.
- Hold result_ready=0 for 100 cycles after a run -> result_valid stays 1, result stable, sample_ready=0, no new START. Then release -> IDLE next cycle.
- RESEED_EACH_RUN=1, two runs -> identical hwa_r_y sequence; first RUN value is the one-step successor of 12'hACE. hwa_r_y never equals 0 over 4096 cycles.
- Assert reset_n=0 at sel=2000 -> all outputs at reset values immediately, taps=0, no result_valid afterwards.
- Force the stub's hwa_done=1 at sel=100 -> seq_err=1 and stays 1 until reset. clear in IDLE -> all taps 0 the next cycle.

Source files
------------

// File: rtl/sc_fir_pkg.sv
// Shared constants and state encoding for the stochastic FIR sequencer.
// Widths follow the 12-bit stochastic resolution of the HWA datapath.
package sc_fir_pkg;

    localparam int SC_N     = 12;
    localparam int SC_POW2N = 4096;
    localparam int SC_NTAPS = 39;

    // Fibonacci taps 12/6/4/1 of x^12+x^6+x^4+x+1
    localparam logic [11:0] SC_LFSR_MASK = 12'h829;
    localparam logic [11:0] SC_LFSR_SEED = 12'hACE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci LFSR producing the R_y random stream; a load takes priority over a step.
// Shifts toward the MSB with the XOR of the masked bits entering at bit 0.
module sc_lfsr #(
    parameter int             W           = 12,
    parameter logic [W-1:0]   MASK        = 12'h829,
    parameter logic [W-1:0]   RESET_VALUE = 12'hACE
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] seed_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = seed_i;
        end else if (en_i) begin
            lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & MASK)};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= RESET_VALUE;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/sc_fir_sequencer.sv
// Sample delay line and run sequencer for the stochastic FIR HWA: one full
// 2^N-cycle window per accepted sample, result presented on a valid/ready port.
module sc_fir_sequencer
    import sc_fir_pkg::*;
#(
    parameter int           N               = SC_N,
    parameter int           NTAPS           = SC_NTAPS,
    parameter logic [N-1:0] LFSR_SEED       = SC_LFSR_SEED[N-1:0],
    parameter logic [N-1:0] LFSR_MASK       = SC_LFSR_MASK[N-1:0],
    parameter bit           RESEED_EACH_RUN = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N:0]               sample_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    input  logic                     clear,
    output logic [NTAPS*(N+1)-1:0]   tap_out,
    output logic                     hwa_start,
    output logic [N-1:0]             hwa_sel_bits,
    output logic [N-1:0]             hwa_r_y,
    input  logic [N:0]               hwa_out,
    input  logic                     hwa_done,
    output logic [N:0]               result,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic                     busy,
    output logic                     seq_err,
    output logic [1:0]               dbg_state
);

    localparam logic [N-1:0] SEL_MAX = '1;

    seq_state_t state_q, state_d;
    logic [N:0]   taps_q [NTAPS];
    logic [N:0]   taps_d [NTAPS];
    logic [N-1:0] sel_q, sel_d;
    logic [N:0]   result_q, result_d;
    logic         rvalid_q, rvalid_d;
    logic         err_q, err_d;
    logic         lfsr_load;
    logic         lfsr_step;

    // Handshakes: a transfer happens on a rising clock edge where valid and
    // ready are both high; valid never drops before its transfer completes.
    always_comb begin
        state_d   = state_q;
        taps_d    = taps_q;
        sel_d     = sel_q;
        result_d  = result_q;
        rvalid_d  = rvalid_q;
        err_d     = err_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;

        if (state_q != IDLE && (hwa_done != (sel_q == SEL_MAX))) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                sel_d = SEL_MAX;
                if (sample_valid) begin
                    taps_d[0] = sample_in;
                    for (int i = 1; i < NTAPS; i++) begin
                        taps_d[i] = taps_q[i-1];
                    end
                    // Seed lands on acceptance so START presents it and the
                    // first RUN cycle already shows its successor.
                    lfsr_load = RESEED_EACH_RUN;
                    state_d   = START;
                end else if (clear) begin
                    for (int i = 0; i < NTAPS; i++) begin
                        taps_d[i] = '0;
                    end
                end
            end
            START: begin
                sel_d     = '0;
                lfsr_step = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                if (sel_q == SEL_MAX) begin
                    result_d = hwa_out;
                    rvalid_d = 1'b1;
                    state_d  = HOLD;
                end else begin
                    sel_d     = sel_q + 1'b1;
                    lfsr_step = 1'b1;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sel_q    <= SEL_MAX;
            result_q <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                taps_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            taps_q   <= taps_d;
        end
    end

    sc_lfsr #(
        .W           (N),
        .MASK        (LFSR_MASK),
        .RESET_VALUE (LFSR_SEED)
    ) u_lfsr (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .load_i  (lfsr_load),
        .en_i    (lfsr_step),
        .seed_i  (LFSR_SEED),
        .value_o (hwa_r_y)
    );

    for (genvar g = 0; g < NTAPS; g++) begin : g_tap
        assign tap_out[g*(N+1) +: (N+1)] = taps_q[g];
    end

    assign sample_ready = (state_q == IDLE);
    assign hwa_start    = (state_q == START);
    assign hwa_sel_bits = sel_q;
    assign result       = result_q;
    assign result_valid = rvalid_q;
    assign busy         = (state_q != IDLE);
    assign seq_err      = err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_sc_fir_sequencer.sv
// Bench for sc_fir_sequencer: a full-size instance with an HWA counting stub,
// plus a 5-bit instance so a 40-sample stream fits in a short run.
module tb_sc_fir_sequencer;

  localparam int BW = 13;
  localparam int SW = 6;
  localparam int NT = 39;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // full-size instance
  logic [BW-1:0]    b_sample_in = '0;
  logic             b_sample_valid = 1'b0;
  logic             b_sample_ready;
  logic             b_clear = 1'b0;
  logic [NT*BW-1:0] b_tap_out;
  logic             b_hwa_start;
  logic [11:0]      b_sel;
  logic [11:0]      b_ry;
  logic [BW-1:0]    b_hwa_out;
  logic             b_hwa_done;
  logic [BW-1:0]    b_result;
  logic             b_result_valid;
  logic             b_result_ready = 1'b0;
  logic             b_busy;
  logic             b_seq_err;
  logic [1:0]       b_state;
  logic             force_done = 1'b0;

  sc_fir_sequencer dut (
    .clock(clock), .reset_n(reset_n), .sample_in(b_sample_in), .sample_valid(b_sample_valid),
    .sample_ready(b_sample_ready), .clear(b_clear), .tap_out(b_tap_out), .hwa_start(b_hwa_start),
    .hwa_sel_bits(b_sel), .hwa_r_y(b_ry), .hwa_out(b_hwa_out), .hwa_done(b_hwa_done),
    .result(b_result), .result_valid(b_result_valid), .result_ready(b_result_ready),
    .busy(b_busy), .seq_err(b_seq_err), .dbg_state(b_state)
  );

  assign b_hwa_done = (b_sel == 12'hFFF) | force_done;
  always @(posedge clock or negedge reset_n)
    if (!reset_n) b_hwa_out <= '0;
    else if (b_hwa_start) b_hwa_out <= '0;
    else if (!b_hwa_done) b_hwa_out <= b_hwa_out + 13'd1;

  // small instance (N=5, x^5+x^3+1)
  logic [SW-1:0]    s_sample_in = '0;
  logic             s_sample_valid = 1'b0;
  logic             s_sample_ready;
  logic             s_clear = 1'b0;
  logic [NT*SW-1:0] s_tap_out;
  logic             s_hwa_start;
  logic [4:0]       s_sel;
  logic [4:0]       s_ry;
  logic [SW-1:0]    s_hwa_out;
  logic             s_hwa_done;
  logic [SW-1:0]    s_result;
  logic             s_result_valid;
  logic             s_result_ready = 1'b1;
  logic             s_busy;
  logic             s_seq_err;
  logic [1:0]       s_state;

  sc_fir_sequencer #(.N(5), .NTAPS(NT), .LFSR_SEED(5'h09), .LFSR_MASK(5'h14), .RESEED_EACH_RUN(1'b1)) dut_s (
    .clock(clock), .reset_n(reset_n), .sample_in(s_sample_in), .sample_valid(s_sample_valid),
    .sample_ready(s_sample_ready), .clear(s_clear), .tap_out(s_tap_out), .hwa_start(s_hwa_start),
    .hwa_sel_bits(s_sel), .hwa_r_y(s_ry), .hwa_out(s_hwa_out), .hwa_done(s_hwa_done),
    .result(s_result), .result_valid(s_result_valid), .result_ready(s_result_ready),
    .busy(s_busy), .seq_err(s_seq_err), .dbg_state(s_state)
  );

  assign s_hwa_done = (s_sel == 5'h1F);
  always @(posedge clock or negedge reset_n)
    if (!reset_n) s_hwa_out <= '0;
    else if (s_hwa_start) s_hwa_out <= '0;
    else if (!s_hwa_done) s_hwa_out <= s_hwa_out + 6'd1;

  // scoreboard bookkeeping
  int total = 0;
  int bad = 0;
  logic [25:0] b_exp_q[$];   // {tap0, result}
  logic [17:0] s_exp_q[$];   // {tap0, tap38, result}
  logic [25:0] b_e;
  logic [17:0] s_e;
  int s_results = 0;
  int b_viol = 0;
  int s_viol = 0;
  int b_acc_cyc = 0;
  int b_start_cyc = -1;
  int b_rv_cyc = -1;
  int b_start_cnt = 0;
  logic b_rv_prev = 1'b0;
  int run_idx = -1;
  int ry_i = 0;
  int ry_zero = 0;
  logic [11:0] ry_log [2][4096];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] lfsr_next(input logic [11:0] q);
    return {q[10:0], q[11] ^ q[5] ^ q[3] ^ q[0]};
  endfunction

  // monitors: sample away from the active edge
  always @(negedge clock) begin
    if (reset_n && b_result_valid && b_result_ready) begin
      if (b_exp_q.size() == 0) check("b_unexpected_result", 64'd1, 64'd0);
      else begin
        b_e = b_exp_q.pop_front();
        check("b_result", 64'(b_result), 64'(b_e[12:0]));
        check("b_tap0_at_result", 64'(b_tap_out[12:0]), 64'(b_e[25:13]));
      end
    end
    if (reset_n && s_result_valid && s_result_ready) begin
      s_results++;
      if (s_exp_q.size() == 0) check("s_unexpected_result", 64'd1, 64'd0);
      else begin
        s_e = s_exp_q.pop_front();
        check("s_result", 64'(s_result), 64'(s_e[5:0]));
        check("s_tap0", 64'(s_tap_out[5:0]), 64'(s_e[17:12]));
        check("s_tap38", 64'(s_tap_out[38*SW +: SW]), 64'(s_e[11:6]));
      end
    end
    if (b_state != 2'd0 && b_sample_ready) b_viol++;
    if (s_state != 2'd0 && s_sample_ready) s_viol++;
    if (b_hwa_start) begin
      b_start_cnt++;
      if (b_start_cyc < 0) b_start_cyc = cyc;
      run_idx++;
      ry_i = 0;
    end
    if (b_result_valid && !b_rv_prev && b_rv_cyc < 0) b_rv_cyc = cyc;
    b_rv_prev = b_result_valid;
    if (b_state == 2'd2) begin
      if (run_idx >= 0 && run_idx < 2 && ry_i < 4096) ry_log[run_idx][ry_i] = b_ry;
      ry_i++;
      if (b_ry == 12'h000) ry_zero++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic b_send(input logic [12:0] d, input logic [12:0] res);
    int n = 0;
    b_sample_in = d;
    b_sample_valid = 1'b1;
    while (!b_sample_ready && n < 10000) begin tick(); n++; end
    if (!b_sample_ready) check("b_send_timeout", 64'd0, 64'd1);
    b_exp_q.push_back({d, res});
    b_acc_cyc = cyc;
    tick();
    b_sample_valid = 1'b0;
  endtask

  task automatic s_send(input logic [5:0] d, input logic [5:0] t38, input logic clr);
    int n = 0;
    s_sample_in = d;
    s_sample_valid = 1'b1;
    s_clear = clr;
    while (!s_sample_ready && n < 200) begin tick(); n++; end
    if (!s_sample_ready) check("s_send_timeout", 64'd0, 64'd1);
    s_exp_q.push_back({d, t38, 6'd31});
    tick();
    s_sample_valid = 1'b0;
    s_clear = 1'b0;
  endtask

  task automatic b_wait_idle();
    int n = 0;
    while (b_state != 2'd0 && n < 6000) begin tick(); n++; end
    check("b_wait_idle", 64'(b_state), 64'd0);
  endtask

  task automatic b_wait_sel(input logic [11:0] v);
    int n = 0;
    while (!(b_state == 2'd2 && b_sel == v) && n < 6000) begin tick(); n++; end
    check("b_wait_sel", 64'(b_sel), 64'(v));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 64'(b_state), 64'd0);
    check({tag, "_taps"}, 64'(b_tap_out == '0), 64'd1);
    check({tag, "_start"}, 64'(b_hwa_start), 64'd0);
    check({tag, "_sel"}, 64'(b_sel), 64'hFFF);
    check({tag, "_ry"}, 64'(b_ry), 64'hACE);
    check({tag, "_result"}, 64'(b_result), 64'd0);
    check({tag, "_rvalid"}, 64'(b_result_valid), 64'd0);
    check({tag, "_seq_err"}, 64'(b_seq_err), 64'd0);
    check({tag, "_busy"}, 64'(b_busy), 64'd0);
  endtask

  initial begin
    int hold_bad;
    int mism;
    int rv_seen;
    int n;
    logic [11:0] m;

    // reset
    repeat (3) tick();
    check_reset_values("rst");
    check("s_rst_sel", 64'(s_sel), 64'h1F);
    check("s_rst_ry", 64'(s_ry), 64'h09);
    reset_n = 1'b1;
    repeat (5) tick();
    check("idle_ready", 64'(b_sample_ready), 64'd1);

    // run 1: first sample, latency and R_y start
    b_result_ready = 1'b1;
    b_send(13'h0800, 13'h0FFF);
    check("r1_start_high", 64'(b_hwa_start), 64'd1);
    check("r1_start_ry", 64'(b_ry), 64'hACE);
    check("r1_start_sel", 64'(b_sel), 64'hFFF);
    check("r1_tap0", 64'(b_tap_out[12:0]), 64'h0800);
    tick();
    check("r1_run_ry", 64'(b_ry), 64'h59C);
    check("r1_run_sel", 64'(b_sel), 64'd0);
    check("r1_run_start_low", 64'(b_hwa_start), 64'd0);
    b_wait_idle();
    check("r1_start_latency", 64'(b_start_cyc - b_acc_cyc), 64'd1);
    check("r1_valid_latency", 64'(b_rv_cyc - b_acc_cyc), 64'd4098);
    check("r1_start_pulses", 64'(b_start_cnt), 64'd1);
    check("r1_result", 64'(b_result), 64'h0FFF);
    check("r1_tap1", 64'(b_tap_out[25:13]), 64'd0);

    // run 2: downstream stalls for 100 cycles
    b_result_ready = 1'b0;
    b_send(13'h1ABC, 13'h0FFF);
    n = 0;
    while (!b_result_valid && n < 6000) begin tick(); n++; end
    check("r2_valid", 64'(b_result_valid), 64'd1);
    b_sample_in = 13'h0055;
    b_sample_valid = 1'b1;
    hold_bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (b_result_valid !== 1'b1 || b_result !== 13'h0FFF || b_sample_ready !== 1'b0 ||
          b_hwa_start !== 1'b0 || b_state !== 2'd3 || b_tap_out[12:0] !== 13'h1ABC) hold_bad++;
    end
    check("r2_hold_stable", 64'(hold_bad), 64'd0);
    b_sample_valid = 1'b0;
    b_result_ready = 1'b1;
    tick();
    check("r2_release_idle", 64'(b_state), 64'd0);
    check("r2_release_rvalid", 64'(b_result_valid), 64'd0);
    check("r2_tap1", 64'(b_tap_out[25:13]), 64'h0800);

    // both runs reseeded: identical R_y streams, matching the polynomial
    mism = 0;
    m = 12'hACE;
    for (int i = 0; i < 4096; i++) begin
      m = lfsr_next(m);
      if (ry_log[0][i] !== m) mism++;
      if (ry_log[1][i] !== ry_log[0][i]) mism++;
    end
    check("ry_sequence", 64'(mism), 64'd0);
    check("ry_never_zero", 64'(ry_zero), 64'd0);

    // run 3: reset mid-run
    b_send(13'h0123, 13'h0FFF);
    b_wait_sel(12'd2000);
    reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    check("midrst_ready", 64'(b_sample_ready), 64'd1);
    b_exp_q.delete();
    repeat (3) tick();
    check("midrst_held_sel", 64'(b_sel), 64'hFFF);
    reset_n = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b_result_valid || b_busy) rv_seen++;
    end
    check("midrst_no_result", 64'(rv_seen), 64'd0);

    // run 4: inconsistent done raises sticky seq_err
    b_send(13'h0777, 13'h0FFE);
    b_wait_sel(12'd100);
    check("err_clear_before", 64'(b_seq_err), 64'd0);
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    check("err_set", 64'(b_seq_err), 64'd1);
    b_wait_idle();
    check("err_sticky_idle", 64'(b_seq_err), 64'd1);
    check("r4_taps_nonzero", 64'(b_tap_out[12:0]), 64'h0777);
    b_clear = 1'b1;
    tick();
    b_clear = 1'b0;
    check("clear_taps", 64'(b_tap_out == '0), 64'd1);
    check("err_sticky_clear", 64'(b_seq_err), 64'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("err_reset", 64'(b_seq_err), 64'd0);

    // small instance: 40 ordered samples with ready tied high
    for (int k = 1; k <= 40; k++) begin
      s_send(6'(k), (k >= 39) ? 6'(k - 38) : 6'd0, 1'b0);
    end
    n = 0;
    while (s_exp_q.size() != 0 && n < 200) begin tick(); n++; end
    while (s_state != 2'd0 && n < 200) begin tick(); n++; end
    check("s_result_count", 64'(s_results), 64'd40);
    check("s_final_tap0", 64'(s_tap_out[5:0]), 64'd40);
    check("s_final_tap38", 64'(s_tap_out[38*SW +: SW]), 64'd2);
    check("s_final_tap1", 64'(s_tap_out[SW +: SW]), 64'd39);

    // sample beats clear; then clear alone zeroes the line
    s_send(6'd7, 6'd3, 1'b1);
    check("s_clear_vs_sample_tap1", 64'(s_tap_out[SW +: SW]), 64'd40);
    n = 0;
    while (s_state != 2'd0 && n < 200) begin tick(); n++; end
    s_clear = 1'b1;
    tick();
    s_clear = 1'b0;
    check("s_clear_taps", 64'(s_tap_out == '0), 64'd1);
    repeat (3) tick();

    check("b_queue_empty", 64'(b_exp_q.size()), 64'd0);
    check("s_queue_empty", 64'(s_exp_q.size()), 64'd0);
    check("b_ready_while_busy", 64'(b_viol), 64'd0);
    check("s_ready_while_busy", 64'(s_viol), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
